div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider serving the execute stage of the five-stage core. The execute stage hands it two operands and a start request for DIV/DIVU instructions and holds the pipeline stalled until the divider raises `ready_o`. The divider then returns a 64-bit result, {remainder, quotient}, which the execute stage writes to HI/LO. It uses a radix-2 restoring algorithm: one quotient bit per clock, with signed operation handled by magnitude conversion and sign fix-up.

## Interface
Parameters: none (width fixed at 32 by `RegBus`).
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset (`RstEnable` = 1'b1)
- signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request; held high by the execute stage until it sees `ready_o`
- annul_i  input  1  abort current division (pipeline flush/exception)
- result_o  output  64  {remainder[63:32], quotient[31:0]}; valid only while `ready_o`=1
- ready_o  output  1  result valid; registered

## Operation
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END. 6-bit step counter `cnt`. 65-bit working register {R[32:0] partial remainder, Q[31:0]}. 32-bit divisor register D.
- DIV_FREE: `ready_o`=0 and `result_o`=0. On an edge with start_i=1 and annul_i=0:
  - if opdata2_i==0, go to DIV_BY_ZERO;
  - else latch magnitudes: |opdata1_i| into Q, R=0, |opdata2_i| into D. Magnitudes are two's-complement negated only when signed_div_i=1 and bit 31=1. Latch sign flags (dividend sign; dividend sign XOR divisor sign). Set cnt=0 and go to DIV_ON.
- DIV_BY_ZERO: next edge goes to DIV_END with result 64'h0.
- DIV_ON, each edge with annul_i=0 and start_i=1:
  - if cnt<32: shift {R,Q} left by 1, then trial = R[32:0] − {1'b0,D}. If trial is non-negative, R=trial and Q[0]=1; else Q[0]=0. Then cnt=cnt+1.
  - if cnt==32: apply sign fix-up. The quotient is negated if the quotient-sign flag is set. The remainder (R[31:0]) is negated if the dividend-sign flag is set. Load result_o, set ready_o=1, go to DIV_END.
- DIV_END: hold result_o and ready_o=1 while start_i=1. On an edge with start_i=0, go to DIV_FREE and clear ready_o and result_o.
- Annul/withdraw: an edge with annul_i=1 in any state, or with start_i=0 in DIV_ON or DIV_BY_ZERO, returns to DIV_FREE with ready_o=0, result_o=0, cnt=0.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is the natural output of the magnitude path; no special case.
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset (asynchronous, any state including mid-division): state=DIV_FREE, cnt=0, ready_o=0, result_o=64'h0, working registers cleared.
- Normal latency: the accept edge is E0. Edges E1..E32 perform the 32 steps. Edge E33 loads the result. ready_o is high in the cycle after E33, i.e. 34 rising edges after the first edge that samples start_i=1.
- Divide-by-zero latency: ready_o is high after E1 (2 edges).
- ready_o is never combinational from inputs. A new request cannot be accepted in the same edge that leaves DIV_END; at least one DIV_FREE cycle (start_i=0) separates results.
- annul_i has priority over start_i on the same edge.
- Operand inputs are sampled only at E0; later changes are ignored.

## Test plan
- Unsigned 100 / 7 (signed_div_i=0): ready_o rises 34 edges after start, result_o = {32'd2, 32'd14}, held until start_i drops, then 0 the next cycle.
- Signed −7 / 2: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7 / −2: {32'h00000001, 32'hFFFFFFFD}. Signed 0x80000000 / 0xFFFFFFFF: {32'h0, 32'h80000000}.
- 0xFFFFFFFF / 1: unsigned gives quotient 0xFFFFFFFF, remainder 0. Signed gives quotient 0xFFFFFFFF (−1), remainder 0.
- Divide by zero (any dividend): ready_o at 2 edges after start, result_o = 64'h0.
- annul_i pulsed at step cnt=10: next cycle state is DIV_FREE and ready_o=0. An immediate new request 50 / 5 completes in 34 edges with {0, 10}.
- rst asserted asynchronously mid-DIV_ON and mid-DIV_END: ready_o and result_o go to 0 without waiting for a clock edge. After release, 9 / 3 gives {0, 3} in 34 edges.

Source files
------------

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for the execute stage.
// Signed operands are divided as magnitudes and the signs fixed up at the end.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BY_ZERO,
        DIV_ON,
        DIV_END
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] dvsr_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] abs1_d;
    logic [31:0] abs2_d;
    logic [64:0] shift_d;
    logic [33:0] trial_d;
    logic [64:0] work_d;
    logic [31:0] quo_d;
    logic [31:0] rem_d;

    // Operand magnitudes, one restoring step, and final sign fix-up.
    always_comb begin
        abs1_d = opdata1_i;
        abs2_d = opdata2_i;
        if (signed_div_i && opdata1_i[31]) abs1_d = ~opdata1_i + 32'd1;
        if (signed_div_i && opdata2_i[31]) abs2_d = ~opdata2_i + 32'd1;

        shift_d = {work_q[63:0], 1'b0};
        trial_d = {1'b0, shift_d[64:32]} - {2'b00, dvsr_q};
        work_d  = shift_d;
        if (!trial_d[33]) work_d = {trial_d[32:0], shift_d[31:1], 1'b1};

        quo_d = qneg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        rem_d = rneg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
    end

    // Divider control FSM with registered result and ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= 6'd0;
            work_q   <= 65'd0;
            dvsr_q   <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else if (annul_i) begin
            state_q  <= DIV_FREE;
            cnt_q    <= 6'd0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    result_q <= 64'd0;
                    ready_q  <= 1'b0;
                    cnt_q    <= 6'd0;
                    if (start_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= DIV_BY_ZERO;
                        end else begin
                            work_q  <= {33'd0, abs1_d};
                            dvsr_q  <= abs2_d;
                            rneg_q  <= signed_div_i & opdata1_i[31];
                            qneg_q  <= signed_div_i &
                                       (opdata1_i[31] ^ opdata2_i[31]);
                            state_q <= DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (!start_i) begin
                        state_q  <= DIV_FREE;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end else begin
                        state_q  <= DIV_END;
                        result_q <= 64'd0;
                        ready_q  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (!start_i) begin
                        state_q  <= DIV_FREE;
                        cnt_q    <= 6'd0;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end else if (cnt_q != 6'd32) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        result_q <= {rem_d, quo_d};
                        ready_q  <= 1'b1;
                        cnt_q    <= 6'd0;
                        state_q  <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        state_q  <= DIV_FREE;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= DIV_FREE;
                    cnt_q    <= 6'd0;
                    result_q <= 64'd0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed testbench for the multi-cycle divider.
// Each scenario task drives stimulus and checks its own results.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int tests;
    int fails;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start with operands, scramble operands after the accept edge,
    // and count edges until ready_o (bounded at 100).
    task automatic run_div(input logic s, input logic [31:0] a,
                           input logic [31:0] b, output int edges,
                           output logic [63:0] res);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        res          = 64'hx;
        while (edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                opdata1_i    = ~a;
                opdata2_i    = 32'd0;
                signed_div_i = ~s;
            end
            if (ready_o) break;
        end
        res = result_o;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL reset: ready=%b result=%h want 0/0",
                     ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int e;
        logic [63:0] r;
        run_div(1'b0, 32'd100, 32'd7, e, r);
        tests++;
        if (e !== 34 || r !== {32'd2, 32'd14}) begin
            fails++;
            $display("FAIL udiv100_7: edges=%0d result=%h want 34 %h",
                     e, r, {32'd2, 32'd14});
        end
        @(posedge clk);
        #1;
        tests++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
            fails++;
            $display("FAIL hold: ready=%b result=%h", ready_o, result_o);
        end
        drop_start();
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL release: ready=%b result=%h want 0/0",
                     ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        int e;
        logic [63:0] r;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, e, r);
        tests++;
        if (e !== 34 || r !== 64'hFFFFFFFF_FFFFFFFD) begin
            fails++;
            $display("FAIL sdiv_m7_2: edges=%0d result=%h want 34 %h",
                     e, r, 64'hFFFFFFFF_FFFFFFFD);
        end
        drop_start();
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, e, r);
        tests++;
        if (e !== 34 || r !== 64'h00000001_FFFFFFFD) begin
            fails++;
            $display("FAIL sdiv_7_m2: edges=%0d result=%h want 34 %h",
                     e, r, 64'h00000001_FFFFFFFD);
        end
        drop_start();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, r);
        tests++;
        if (e !== 34 || r !== 64'h00000000_80000000) begin
            fails++;
            $display("FAIL sdiv_ovf: edges=%0d result=%h want 34 %h",
                     e, r, 64'h00000000_80000000);
        end
        drop_start();
    endtask

    task automatic test_boundary();
        int e;
        logic [63:0] r;
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, e, r);
        tests++;
        if (e !== 34 || r !== 64'h00000000_FFFFFFFF) begin
            fails++;
            $display("FAIL udiv_max_1: edges=%0d result=%h", e, r);
        end
        drop_start();
        run_div(1'b1, 32'hFFFFFFFF, 32'd1, e, r);
        tests++;
        if (e !== 34 || r !== 64'h00000000_FFFFFFFF) begin
            fails++;
            $display("FAIL sdiv_m1_1: edges=%0d result=%h", e, r);
        end
        drop_start();
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, e, r);
        tests++;
        if (e !== 34 || r !== 64'h80000000_00000000) begin
            fails++;
            $display("FAIL udiv_big: edges=%0d result=%h want %h",
                     e, r, 64'h80000000_00000000);
        end
        drop_start();
    endtask

    task automatic test_div_zero();
        int e;
        logic [63:0] r;
        run_div(1'b0, 32'd1234, 32'd0, e, r);
        tests++;
        if (e !== 2 || r !== 64'd0) begin
            fails++;
            $display("FAIL divzero: edges=%0d result=%h want 2 0", e, r);
        end
        drop_start();
    endtask

    task automatic test_annul();
        int e;
        logic [63:0] r;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL annul: ready=%b result=%h want 0/0",
                     ready_o, result_o);
        end
        annul_i = 1'b0;
        run_div(1'b0, 32'd50, 32'd5, e, r);
        tests++;
        if (e !== 34 || r !== {32'd0, 32'd10}) begin
            fails++;
            $display("FAIL after_annul: edges=%0d result=%h", e, r);
        end
        drop_start();
    endtask

    task automatic test_async_reset();
        int e;
        logic [63:0] r;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd4;
        start_i      = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL rst_on: ready=%b result=%h", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        run_div(1'b0, 32'd77, 32'd4, e, r);
        tests++;
        if (r !== {32'd1, 32'd19}) begin
            fails++;
            $display("FAIL pre_rst_end: result=%h want %h",
                     r, {32'd1, 32'd19});
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL rst_end: ready=%b result=%h", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        run_div(1'b0, 32'd9, 32'd3, e, r);
        tests++;
        if (e !== 34 || r !== {32'd0, 32'd3}) begin
            fails++;
            $display("FAIL after_rst: edges=%0d result=%h", e, r);
        end
        drop_start();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_boundary();
        test_div_zero();
        test_annul();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
